wb_dp_ram_pl: RTL and testbench
===============================

WB_DP_RAM_PL -- requirements
Module: wb_dp_ram_pl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: port data width in bits; a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 14: word-address width of each port.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_WIDTH: number of implemented words, at most 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter OUT_REG, default 0: 1 adds an output register, making read latency 2.
REQ-005 The block SHALL have parameter INIT_FILE, default "": hex memory init file; empty means no init.
REQ-006 Port list: clk  in  1  single clock for both ports.
REQ-007 Port list: rst_n  in  1  reset, asynchronous, active-low.
REQ-008 Per port p in {a,b}: p_adr_i  in  ADDR_WIDTH  word address.
REQ-009 Per port: p_dat_i  in  DATA_WIDTH  write data.
REQ-010 Per port: p_dat_o  out  DATA_WIDTH  read data.
REQ-011 Per port: p_we_i  in  1  write enable.
REQ-012 Per port: p_sel_i  in  DATA_WIDTH/8  byte enables.
REQ-013 Per port: p_stb_i  in  1  strobe.
REQ-014 Per port: p_cyc_i  in  1  cycle.
REQ-015 Per port: p_stall_o  out  1  stall.
REQ-016 Per port: p_ack_o  out  1  acknowledge.
REQ-017 Per port: p_err_o  out  1  error.

Function
REQ-018 Each port SHALL be Wishbone B4 pipelined; a request is accepted in any cycle with cyc&stb&!stall.
REQ-019 p_stall_o SHALL be 0 in all cycles, giving one access per port per clock.
REQ-020 Latency SHALL be fixed: ack/err asserts exactly 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) after acceptance, one response per request, in order.
REQ-021 Writes SHALL update only bytes with sel bit set.
REQ-022 Reads SHALL be read-first: a read to the same or the other port's address in the cycle of a write returns the old data.
REQ-023 Write collision (both ports write the same address in one cycle): port A bytes SHALL win where both sel bits are set; port B bytes SHALL land elsewhere; both ports are acked.
REQ-024 Each port SHALL keep an outstanding-response counter; width SHALL be 2 bits; incremented on accept, decremented on response.
REQ-025 If cyc drops while responses are outstanding, the counter SHALL clear and the pending ack/err pulses SHALL be suppressed; the memory write, if already accepted, SHALL persist.
REQ-026 p_dat_o SHALL hold its last value when no read response is issued.
REQ-027 Address wrap SHALL NOT occur; addresses >= DEPTH are out of range per REQ-034/035.

Reset
REQ-028 While rst_n=0: ack_o=0, err_o=0, and the outstanding counters=0 on both ports.
REQ-029 While rst_n=0: p_dat_o=0 on both ports.
REQ-030 While rst_n=0: all pipeline valid bits are cleared.
REQ-031 Reset assertion SHALL be asynchronous; deassertion SHALL be sampled on clk.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Requests in flight at reset assertion SHALL be dropped without response.

Configuration
REQ-034 With WB_DP_RAM_PL_ADDR_ERR_EN defined: an access with adr >= DEPTH SHALL return err_o=1 and ack_o=0 at normal latency, and an out-of-range write SHALL be discarded.
REQ-035 Without the macro: out-of-range addresses SHALL alias modulo DEPTH, they SHALL be acked, and err_o SHALL be tied 0.

Structure
REQ-036 A shared package wb_ram_pkg SHALL hold a response-type enum {RSP_NONE, RSP_ACK, RSP_ERR} and a latency constant function.
REQ-037 One sub-module wb_ram_port_ctrl SHALL be instantiated per port, covering acceptance, the latency pipeline, the outstanding counter and abort; the RAM array SHALL live in the top.

Verification
REQ-038 Scenario: A writes 0xDEADBEEF to adr 5, then reads adr 5 with OUT_REG=0 -> ack 1 cycle after each request; dat_o=0xDEADBEEF.
REQ-039 Scenario: A issues 4 back-to-back reads, adr 0..3, with OUT_REG=1 -> stall stays 0; 4 consecutive acks starting 2 cycles after the first request, data in order.
REQ-040 Scenario: same cycle, A writes 0x11111111 with sel=0011 and B writes 0x22222222 with sel=1111, both to adr 9 -> memory reads 0x22221111.
REQ-041 Scenario: B reads adr 7 (old 0xA5A5A5A5) while A writes 0x5A5A5A5A to adr 7 -> B gets 0xA5A5A5A5; the next B read gets 0x5A5A5A5A.
REQ-042 Scenario: A read accepted, cyc dropped the next cycle with OUT_REG=1 -> no ack is seen; the counter returns to 0.
REQ-043 Scenario: DEPTH=1000 with the macro defined, write to adr 1000 -> err=1, ack=0, and word 1000 mod 1000 = 0 is unchanged.

Source files
------------

// File: rtl/wb_ram_pkg.sv
// wb_ram_pkg: shared types and helpers for the pipelined Wishbone dual-port RAM
//   rsp_t    : response kind carried down the latency pipeline
//   stage_t  : one pipeline stage (response kind + read flag)
//   latency(): read/ack latency in cycles for a given OUT_REG setting
package wb_ram_pkg;
    typedef enum logic [1:0] {RSP_NONE, RSP_ACK, RSP_ERR} rsp_t;
    typedef struct packed {
        rsp_t rsp;
        logic rd;
    } stage_t;
    localparam stage_t STG_IDLE = '{rsp: RSP_NONE, rd: 1'b0};
    localparam int CNT_W = 2;
    function automatic int latency(input int out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction
endpackage

// File: rtl/wb_ram_port_ctrl.sv
// wb_ram_port_ctrl: per-port Wishbone B4 pipelined control
//   clk, rst_n     : clock, async active-low reset
//   cyc_i, stb_i   : bus cycle / strobe
//   we_i           : write request
//   oor_i          : address out of range (becomes an error response)
//   stall_o        : always 0, one request per clock
//   ack_o, err_o   : response at fixed latency
//   acc_o          : request accepted this cycle
//   ld1_o          : accepted read-ack, capture RAM read data this edge
//   ld2_o          : read-ack in stage 1 survives to the output register
module wb_ram_port_ctrl
    import wb_ram_pkg::*;
#(
    parameter int OUT_REG = 0
)(
    input  logic clk,
    input  logic rst_n,
    input  logic cyc_i,
    input  logic stb_i,
    input  logic we_i,
    input  logic oor_i,
    output logic stall_o,
    output logic ack_o,
    output logic err_o,
    output logic acc_o,
    output logic ld1_o,
    output logic ld2_o
);
    localparam int LAT = latency(OUT_REG);
    stage_t s1_q, s1_d, s2_q, s2_d, out;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        stall_o  = 1'b0;
        acc_o    = cyc_i & stb_i;
        s1_d.rsp = !acc_o ? RSP_NONE : oor_i ? RSP_ERR : RSP_ACK;
        s1_d.rd  = acc_o & ~we_i;
        // dropping cyc kills anything not yet presented on the bus
        s2_d     = cyc_i ? s1_q : STG_IDLE;
        out      = (LAT == 2) ? s2_q : s1_q;
        ack_o    = out.rsp == RSP_ACK;
        err_o    = out.rsp == RSP_ERR;
        ld1_o    = (s1_d.rsp == RSP_ACK) & s1_d.rd;
        ld2_o    = cyc_i & (s1_q.rsp == RSP_ACK) & s1_q.rd;
        cnt_d    = cyc_i ? cnt_q + CNT_W'(acc_o) - CNT_W'(out.rsp != RSP_NONE) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= STG_IDLE;
            s2_q  <= STG_IDLE;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wb_dp_ram_pl.sv
// wb_dp_ram_pl: true dual-port RAM with two Wishbone B4 pipelined ports
module wb_dp_ram_pl
    import wb_ram_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 14,
    parameter int    DEPTH      = 2**ADDR_WIDTH,
    parameter int    OUT_REG    = 0,
    parameter string INIT_FILE  = ""
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   a_adr_i,
    input  logic [DATA_WIDTH-1:0]   a_dat_i,
    output logic [DATA_WIDTH-1:0]   a_dat_o,
    input  logic                    a_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_sel_i,
    input  logic                    a_stb_i,
    input  logic                    a_cyc_i,
    output logic                    a_stall_o,
    output logic                    a_ack_o,
    output logic                    a_err_o,
    input  logic [ADDR_WIDTH-1:0]   b_adr_i,
    input  logic [DATA_WIDTH-1:0]   b_dat_i,
    output logic [DATA_WIDTH-1:0]   b_dat_o,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_sel_i,
    input  logic                    b_stb_i,
    input  logic                    b_cyc_i,
    output logic                    b_stall_o,
    output logic                    b_ack_o,
    output logic                    b_err_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] adr [2];
    logic [IW-1:0]         idx [2];
    logic [NB-1:0]         sel [2];
    logic [DATA_WIDTH-1:0] wdat [2], rdat [2], rd1_q [2], dat_q [2], dat_d [2];
    logic                  oor [2], wr [2], we [2], acc [2], ld1 [2], ld2 [2];
    wb_ram_port_ctrl #(.OUT_REG(OUT_REG)) u_a (
        .clk(clk), .rst_n(rst_n), .cyc_i(a_cyc_i), .stb_i(a_stb_i), .we_i(a_we_i),
        .oor_i(oor[0]), .stall_o(a_stall_o), .ack_o(a_ack_o), .err_o(a_err_o),
        .acc_o(acc[0]), .ld1_o(ld1[0]), .ld2_o(ld2[0])
    );
    wb_ram_port_ctrl #(.OUT_REG(OUT_REG)) u_b (
        .clk(clk), .rst_n(rst_n), .cyc_i(b_cyc_i), .stb_i(b_stb_i), .we_i(b_we_i),
        .oor_i(oor[1]), .stall_o(b_stall_o), .ack_o(b_ack_o), .err_o(b_err_o),
        .acc_o(acc[1]), .ld1_o(ld1[1]), .ld2_o(ld2[1])
    );
    always_comb begin
        adr[0]  = a_adr_i;
        adr[1]  = b_adr_i;
        wdat[0] = a_dat_i;
        wdat[1] = b_dat_i;
        sel[0]  = a_sel_i;
        sel[1]  = b_sel_i;
        we[0]   = a_we_i;
        we[1]   = b_we_i;
        for (int p = 0; p < 2; p++) begin
            idx[p]   = IW'(adr[p] % DEPTH);
`ifdef WB_DP_RAM_PL_ADDR_ERR_EN
            oor[p]   = {1'b0, adr[p]} >= (ADDR_WIDTH+1)'(DEPTH);
`else
            oor[p]   = 1'b0;
`endif
            wr[p]    = acc[p] & we[p] & ~oor[p];
            rdat[p]  = mem[idx[p]];
            dat_d[p] = (OUT_REG != 0) ? (ld2[p] ? rd1_q[p] : dat_q[p])
                                      : (ld1[p] ? rdat[p] : dat_q[p]);
        end
    end
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--)
            for (int k = 0; k < NB; k++)
                if (wr[p] && sel[p][k]) mem[idx[p]][8*k +: 8] <= wdat[p][8*k +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                rd1_q[p] <= '0;
                dat_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (ld1[p]) rd1_q[p] <= rdat[p];
                dat_q[p] <= dat_d[p];
            end
        end
    end
    assign a_dat_o = dat_q[0];
    assign b_dat_o = dat_q[1];
endmodule

// File: tb/tb_wb_dp_ram_pl.sv
// tb_wb_dp_ram_pl: table-driven scoreboard bench, OUT_REG=0 and OUT_REG=1 DUTs fed the same stimulus
module tb_wb_dp_ram_pl;
    localparam int AW  = 10;
    localparam int DEP = 1000;
`ifdef WB_DP_RAM_PL_ADDR_ERR_EN
    localparam bit          ERR_EN   = 1'b1;
    localparam logic [31:0] W0_AFTER = 32'h0000_0010;
`else
    localparam bit          ERR_EN   = 1'b0;
    localparam logic [31:0] W0_AFTER = 32'h0BAD_BEEF;
`endif
    typedef struct packed {
        logic cyc, stb, we, chk;
        logic [AW-1:0] adr;
        logic [31:0] dat;
        logic [3:0] sel;
        logic [31:0] xd;
    } req_t;
    typedef struct packed { req_t a; req_t b; } vec_t;
    typedef struct packed { int due; logic err; logic rd; logic [31:0] dat; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cyc [2], stb [2], we [2];
    logic [AW-1:0] adr [2];
    logic [31:0] wdat [2];
    logic [3:0] sel [2];
    logic ack [4], err [4], stall [4];
    logic [31:0] dato [4];
    exp_t sb [4][$];
    logic [31:0] dexp [4];
    logic [31:0] mem_m [DEP];
    int total = 0, bad = 0, e = 0;
    vec_t tbl [$];

    always #5 clk = ~clk;

    wb_dp_ram_pl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEP), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_adr_i(adr[0]), .a_dat_i(wdat[0]), .a_dat_o(dato[0]), .a_we_i(we[0]), .a_sel_i(sel[0]),
        .a_stb_i(stb[0]), .a_cyc_i(cyc[0]), .a_stall_o(stall[0]), .a_ack_o(ack[0]), .a_err_o(err[0]),
        .b_adr_i(adr[1]), .b_dat_i(wdat[1]), .b_dat_o(dato[1]), .b_we_i(we[1]), .b_sel_i(sel[1]),
        .b_stb_i(stb[1]), .b_cyc_i(cyc[1]), .b_stall_o(stall[1]), .b_ack_o(ack[1]), .b_err_o(err[1])
    );
    wb_dp_ram_pl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEP), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_adr_i(adr[0]), .a_dat_i(wdat[0]), .a_dat_o(dato[2]), .a_we_i(we[0]), .a_sel_i(sel[0]),
        .a_stb_i(stb[0]), .a_cyc_i(cyc[0]), .a_stall_o(stall[2]), .a_ack_o(ack[2]), .a_err_o(err[2]),
        .b_adr_i(adr[1]), .b_dat_i(wdat[1]), .b_dat_o(dato[3]), .b_we_i(we[1]), .b_sel_i(sel[1]),
        .b_stb_i(stb[1]), .b_cyc_i(cyc[1]), .b_stall_o(stall[3]), .b_ack_o(ack[3]), .b_err_o(err[3])
    );

    function automatic req_t idle();
        req_t r;
        r = '0;
        r.cyc = 1'b1;
        return r;
    endfunction
    function automatic req_t wr(input int a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r = idle();
        r.stb = 1'b1;
        r.we = 1'b1;
        r.adr = AW'(a);
        r.dat = d;
        r.sel = s;
        return r;
    endfunction
    function automatic req_t rd(input int a);
        req_t r;
        r = idle();
        r.stb = 1'b1;
        r.adr = AW'(a);
        return r;
    endfunction
    function automatic req_t rdc(input int a, input logic [31:0] x);
        req_t r;
        r = rd(a);
        r.chk = 1'b1;
        r.xd = x;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic chk_cnt(input string nm, input int want);
        chk({nm, " d0a"}, 32'(dut0.u_a.cnt_q), 32'(want));
        chk({nm, " d0b"}, 32'(dut0.u_b.cnt_q), 32'(want));
        chk({nm, " d1a"}, 32'(dut1.u_a.cnt_q), 32'(want));
        chk({nm, " d1b"}, 32'(dut1.u_b.cnt_q), 32'(want));
    endtask

    // drive one cycle of requests, update the reference memory and push expected responses
    task automatic drive(input vec_t v);
        req_t r [2];
        logic [31:0] rv [2];
        int ix [2];
        logic oo [2];
        int k, i;
        k = e + 1;
        r[0] = v.a;
        r[1] = v.b;
        for (int p = 0; p < 2; p++) begin
            cyc[p]  = r[p].cyc;
            stb[p]  = r[p].stb;
            we[p]   = r[p].we;
            adr[p]  = r[p].adr;
            wdat[p] = r[p].dat;
            sel[p]  = r[p].sel;
            ix[p]   = int'(r[p].adr) % DEP;
            oo[p]   = ERR_EN && (int'(r[p].adr) >= DEP);
            rv[p]   = mem_m[ix[p]];
        end
        for (int p = 0; p < 2; p++)
            for (int d = 0; d < 2; d++) begin
                i = d * 2 + p;
                if (!r[p].cyc)
                    while (sb[i].size() > 0 && sb[i][$].due >= k) void'(sb[i].pop_back());
                if (r[p].cyc && r[p].stb)
                    sb[i].push_back('{due: k + d, err: oo[p], rd: !r[p].we,
                                      dat: r[p].chk ? r[p].xd : rv[p]});
            end
        for (int p = 1; p >= 0; p--)
            if (r[p].cyc && r[p].stb && r[p].we && !oo[p])
                for (int b = 0; b < 4; b++)
                    if (r[p].sel[b]) mem_m[ix[p]][8*b +: 8] = r[p].dat[8*b +: 8];
    endtask

    task automatic step();
        exp_t x;
        logic wa, wer;
        @(posedge clk);
        e++;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wa = 1'b0;
            wer = 1'b0;
            if (sb[i].size() > 0 && sb[i][0].due == e) begin
                x = sb[i].pop_front();
                wa = !x.err;
                wer = x.err;
                if (x.rd && !x.err) dexp[i] = x.dat;
            end
            chk($sformatf("ack d%0d p%0d e%0d", i / 2, i % 2, e), 32'(ack[i]), 32'(wa));
            chk($sformatf("err d%0d p%0d e%0d", i / 2, i % 2, e), 32'(err[i]), 32'(wer));
            chk($sformatf("dat d%0d p%0d e%0d", i / 2, i % 2, e), dato[i], dexp[i]);
            chk($sformatf("stall d%0d p%0d e%0d", i / 2, i % 2, e), 32'(stall[i]), 32'(0));
        end
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 4; i++) dexp[i] = '0;
        v = '{a: idle(), b: idle()};
        v.a.cyc = 1'b0;
        v.b.cyc = 1'b0;
        drive(v);
        step();
        step();
        chk_cnt("cnt reset", 0);
        rst_n = 1'b1;

        tbl.push_back('{a: wr(5, 32'hDEADBEEF, 4'hF), b: idle()});
        tbl.push_back('{a: rdc(5, 32'hDEADBEEF),      b: idle()});
        tbl.push_back('{a: wr(0, 32'h0000_0010, 4'hF), b: wr(1, 32'h0000_0011, 4'hF)});
        tbl.push_back('{a: wr(2, 32'h0000_0012, 4'hF), b: wr(3, 32'h0000_0013, 4'hF)});
        tbl.push_back('{a: rdc(0, 32'h0000_0010), b: idle()});
        tbl.push_back('{a: rdc(1, 32'h0000_0011), b: idle()});
        tbl.push_back('{a: rdc(2, 32'h0000_0012), b: idle()});
        tbl.push_back('{a: rdc(3, 32'h0000_0013), b: idle()});
        tbl.push_back('{a: wr(9, 32'h1111_1111, 4'h3), b: wr(9, 32'h2222_2222, 4'hF)});
        tbl.push_back('{a: rdc(9, 32'h2222_1111), b: wr(7, 32'hA5A5_A5A5, 4'hF)});
        tbl.push_back('{a: wr(7, 32'h5A5A_5A5A, 4'hF), b: rdc(7, 32'hA5A5_A5A5)});
        tbl.push_back('{a: wr(12, 32'hFFFF_FFFF, 4'hF), b: rdc(7, 32'h5A5A_5A5A)});
        tbl.push_back('{a: wr(12, 32'h0000_0000, 4'h5), b: idle()});
        tbl.push_back('{a: rdc(12, 32'hFF00_FF00), b: rdc(9, 32'h2222_1111)});
        tbl.push_back('{a: idle(), b: idle()});
        tbl.push_back('{a: rdc(5, 32'hDEADBEEF), b: rdc(5, 32'hDEADBEEF)});
        tbl.push_back('{a: wr(1000, 32'h0BAD_BEEF, 4'hF), b: idle()});
        tbl.push_back('{a: rdc(0, W0_AFTER), b: rd(1003)});
        v = '{a: idle(), b: idle()};
        v.a.we = 1'b1;
        v.a.adr = AW'(5);
        v.a.sel = 4'hF;
        tbl.push_back(v);
        tbl.push_back('{a: rdc(5, 32'hDEADBEEF), b: idle()});
        for (int i = 0; i < 4; i++) tbl.push_back('{a: idle(), b: idle()});
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            step();
        end

        drive('{a: rd(5), b: idle()});
        step();
        chk("abort cnt accepted", 32'(dut1.u_a.cnt_q), 32'(1));
        v = '{a: idle(), b: idle()};
        v.a.cyc = 1'b0;
        drive(v);
        step();
        chk_cnt("abort cnt cleared", 0);
        drive('{a: idle(), b: idle()});
        step();
        step();

        drive('{a: rd(9), b: rd(12)});
        step();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            dexp[i] = '0;
            chk($sformatf("rst ack %0d", i), 32'(ack[i]), 32'(0));
            chk($sformatf("rst err %0d", i), 32'(err[i]), 32'(0));
            chk($sformatf("rst dat %0d", i), dato[i], 32'(0));
        end
        chk_cnt("rst cnt", 0);
        v = '{a: idle(), b: idle()};
        v.a.cyc = 1'b0;
        v.b.cyc = 1'b0;
        drive(v);
        step();
        rst_n = 1'b1;
        drive('{a: idle(), b: idle()});
        step();
        drive('{a: rdc(5, 32'hDEADBEEF), b: rdc(9, 32'h2222_1111)});
        step();
        for (int i = 0; i < 3; i++) begin
            drive('{a: idle(), b: idle()});
            step();
        end
        for (int i = 0; i < 4; i++) chk($sformatf("drained %0d", i), 32'(sb[i].size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
